// File: rtl/riscv_pkg.sv
// Shared RV32I opcodes and instruction formats for the encoder.
// Used by instr_encoder and imm_packer.
package riscv_pkg;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_e;

    function automatic fmt_e decode_fmt(input logic [6:0] op);
        fmt_e f;
        case (op)
            OP_REG:                    f = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR:  f = FMT_I;
            OP_STORE:                  f = FMT_S;
            OP_BRANCH:                 f = FMT_B;
            OP_LUI, OP_AUIPC:          f = FMT_U;
            OP_JAL:                    f = FMT_J;
            default:                   f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_packer.sv
// Scatters an ImmExt-style immediate into instruction bit positions.
// Range/alignment error only exists when INSTR_ENC_RANGE_CHECK_EN is defined.
module imm_packer
    import riscv_pkg::*;
(
    input  fmt_e        i_fmt,
    input  logic [31:0] i_imm,
    output logic [31:0] o_bits,
    output logic        o_range_err
);

    always_comb begin
        o_bits = '0;
        case (i_fmt)
            FMT_I: o_bits = {i_imm[11:0], 20'b0};
            FMT_S: o_bits = {i_imm[11:5], 13'b0, i_imm[4:0], 7'b0};
            FMT_B: o_bits = {i_imm[12], i_imm[10:5], 13'b0,
                             i_imm[4:1], i_imm[11], 7'b0};
            FMT_U: o_bits = {i_imm[31:12], 12'b0};
            FMT_J: o_bits = {i_imm[20], i_imm[10:1], i_imm[11],
                             i_imm[19:12], 12'b0};
            default: o_bits = '0;
        endcase
    end

`ifdef INSTR_ENC_RANGE_CHECK_EN
    logic w_fit12;
    logic w_fit13;
    logic w_fit21;

    // Value fits a signed N-bit field when all bits above N-1 match the sign.
    assign w_fit12 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
    assign w_fit13 = (&i_imm[31:12]) | ~(|i_imm[31:12]);
    assign w_fit21 = (&i_imm[31:20]) | ~(|i_imm[31:20]);

    always_comb begin
        o_range_err = 1'b0;
        case (i_fmt)
            FMT_I, FMT_S: o_range_err = ~w_fit12;
            FMT_B:        o_range_err = ~w_fit13 | i_imm[0];
            FMT_J:        o_range_err = ~w_fit21 | i_imm[0];
            FMT_U:        o_range_err = |i_imm[11:0];
            default:      o_range_err = 1'b0;
        endcase
    end
`else
    assign o_range_err = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Two-stage RV32I instruction encoder with byte-address counter.
// Define INSTR_ENC_RANGE_CHECK_EN to flag unrepresentable immediates.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [WIDTH-1:0]  in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err
);

    fmt_e              w_fmt;
    logic [WIDTH-1:0]  w_fields;
    logic [WIDTH-1:0]  w_imm_bits;
    logic              w_range_err;
    logic              w_s1_load;
    logic              w_s2_load;

    logic              r_s1_valid;
    fmt_e              r_s1_fmt;
    logic [WIDTH-1:0]  r_s1_word;
    logic              r_s1_rerr;

    logic              r_s2_valid;
    logic [WIDTH-1:0]  r_s2_word;
    logic              r_s2_err;
    logic [ADDR_W-1:0] r_addr;

    assign w_fmt = decode_fmt(in_opcode);

    imm_packer u_imm_packer (
        .i_fmt       (w_fmt),
        .i_imm       (in_imm),
        .o_bits      (w_imm_bits),
        .o_range_err (w_range_err)
    );

    // BAD leaves every field zero, so its word is all zeros.
    always_comb begin
        w_fields = '0;
        case (w_fmt)
            FMT_R:        w_fields = {in_funct7, in_rs2, in_rs1,
                                      in_funct3, in_rd, in_opcode};
            FMT_I:        w_fields = {12'b0, in_rs1, in_funct3,
                                      in_rd, in_opcode};
            FMT_S, FMT_B: w_fields = {7'b0, in_rs2, in_rs1,
                                      in_funct3, 5'b0, in_opcode};
            FMT_U, FMT_J: w_fields = {20'b0, in_rd, in_opcode};
            default:      w_fields = '0;
        endcase
    end

    assign w_s2_load = ~r_s2_valid | out_ready;
    assign w_s1_load = ~r_s1_valid | w_s2_load;
    assign in_ready  = w_s1_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_fmt   <= FMT_R;
            r_s1_word  <= '0;
            r_s1_rerr  <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_fmt  <= w_fmt;
                r_s1_word <= w_fields | w_imm_bits;
                r_s1_rerr <= w_range_err;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_word  <= '0;
            r_s2_err   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_word <= r_s1_word;
                r_s2_err  <= (r_s1_fmt == FMT_BAD) | r_s1_rerr;
            end
        end
    end

    // Clear has priority over the advance on a same-cycle handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
        end else if (clear) begin
            r_addr <= '0;
        end else if (r_s2_valid && out_ready) begin
            r_addr <= r_addr + ADDR_W'(4);
        end
    end

    assign out_valid = r_s2_valid;
    assign out_instr = r_s2_word;
    assign out_err   = r_s2_err;
    assign out_addr  = r_addr;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder; expected error flags follow
// INSTR_ENC_RANGE_CHECK_EN.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [9:0]  out_addr;
    logic        out_err;

    logic        in_ready4, out_valid4, out_err4;
    logic [31:0] out_instr4;
    logic [3:0]  out_addr4;

    int checks = 0;
    int errors = 0;
    int exp_addr = 0;

    always #5 clk = ~clk;

    instr_encoder #(.WIDTH(32), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err)
    );

    instr_encoder #(.WIDTH(32), .ADDR_W(4)) dut4 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready4),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_imm(in_imm), .out_valid(out_valid4), .out_ready(out_ready),
        .out_instr(out_instr4), .out_addr(out_addr4), .out_err(out_err4)
    );

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] instr;
        logic        err_off;
        logic        err_on;
        logic        rt;
    } vec_t;

    vec_t vecs[$];

    // Immediate generator: recovers ImmExt from an encoded word.
    function automatic logic [31:0] immgen(input logic [31:0] w);
        case (w[6:0])
            7'b0010011, 7'b0000011, 7'b1100111:
                return {{20{w[31]}}, w[31:20]};
            7'b0100011:
                return {{20{w[31]}}, w[31:25], w[11:7]};
            7'b1100011:
                return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                return {w[31:12], 12'b0};
            7'b1101111:
                return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default:
                return 32'd0;
        endcase
    endfunction

    task automatic set_fields(input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm);
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
    endtask

    task automatic add(input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm, input logic [31:0] instr,
                       input logic err_off, input logic err_on,
                       input logic rt);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.f3 = f3; v.f7 = f7; v.imm = imm; v.instr = instr;
        v.err_off = err_off; v.err_on = err_on; v.rt = rt;
        vecs.push_back(v);
    endtask

    task automatic test_reset;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_fields(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_instr !== 32'd0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: valid=%b instr=%h err=%b want 0/0/0",
                     out_valid, out_instr, out_err);
        end
        checks++;
        if (out_addr !== 10'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_addr_ready: addr=%0d ready=%b want 0/1",
                     out_addr, in_ready);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: valid=%b ready=%b want 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        set_fields(7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hAAAAA000);
        in_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready1: got %b want 1", in_ready);
        end
        set_fields(7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'hBBBBB000);
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_full: ready=%b valid=%b want 0/1",
                     in_ready, out_valid);
        end
        set_fields(7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'hCCCCC000);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_instr !== 32'hAAAAA0B7 || out_addr !== 10'd0 ||
                out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_stable: instr=%h addr=%0d v=%b r=%b want aaaaa0b7/0/1/0",
                         out_instr, out_addr, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_comb: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_instr !== 32'hBBBBB137 || out_addr !== 10'd4) begin
            errors++;
            $display("FAIL bp_word2: instr=%h addr=%0d want bbbbb137/4",
                     out_instr, out_addr);
        end
        @(posedge clk); #1;
        checks++;
        if (out_instr !== 32'hCCCCC1B7 || out_addr !== 10'd8 ||
            out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_word3: instr=%h addr=%0d v=%b want ccccc1b7/8/1",
                     out_instr, out_addr, out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || out_addr !== 10'd12) begin
            errors++;
            $display("FAIL bp_drain: v=%b addr=%0d want 0/12",
                     out_valid, out_addr);
        end
    endtask

    task automatic test_clear;
        set_fields(7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        checks++;
        if (out_addr !== 10'd0 || out_addr4 !== 4'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_hs: addr=%0d addr4=%0d v=%b want 0/0/0",
                     out_addr, out_addr4, out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] words [4];
        for (int i = 0; i < 4; i++)
            words[i] = 32'h00001037 | (32'(i) << 12) | (32'(i + 1) << 7);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                set_fields(7'h37, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0,
                           32'h00001000 | (32'(i) << 12));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (i >= 1) begin
                checks++;
                if (out_valid !== 1'b1 || out_instr !== words[i-1] ||
                    out_addr !== 10'(4 * (i - 1)) ||
                    out_addr4 !== 4'(4 * (i - 1))) begin
                    errors++;
                    $display("FAIL b2b_%0d: v=%b instr=%h addr=%0d addr4=%0d want 1/%h/%0d",
                             i - 1, out_valid, out_instr, out_addr, out_addr4,
                             words[i-1], 4 * (i - 1));
                end
            end
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || out_addr !== 10'd16 || out_addr4 !== 4'd0) begin
            errors++;
            $display("FAIL wrap: v=%b addr=%0d addr4=%0d want 0/16/0",
                     out_valid, out_addr, out_addr4);
        end
        exp_addr = 16;
    endtask

    task automatic test_encodings;
        logic exp_err;
        add(7'h13, 5'd4, 5'd6, 5'd0, 3'd0, 7'd0, 32'd30,       32'h01E30213, 0, 0, 1);
        add(7'h23, 5'd0, 5'd6, 5'd5, 3'd2, 7'd0, 32'd8,        32'h00532423, 0, 0, 1);
        add(7'h63, 5'd0, 5'd6, 5'd7, 3'd1, 7'd0, 32'hFFFFFFFC, 32'hFE731EE3, 0, 0, 1);
        add(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16,       32'h010000EF, 0, 0, 1);
        add(7'h37, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h12345237, 0, 0, 1);
        add(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEADBEEF, 32'h402081B3, 0, 0, 0);
        add(7'h03, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 32'd4,        32'h00412283, 0, 0, 1);
        add(7'h67, 5'd0, 5'd1, 5'd0, 3'd0, 7'd0, 32'd0,        32'h00008067, 0, 0, 1);
        add(7'h17, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000, 32'h00001097, 0, 0, 1);
        add(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 32'h80000013, 0, 0, 1);
        add(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000FFE, 32'h7E000FE3, 0, 0, 1);
        add(7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF00000, 32'h8000006F, 0, 0, 1);
        add(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h80000013, 0, 1, 0);
        add(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,        32'h00000263, 0, 1, 0);
        add(7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 32'h12345037, 0, 1, 0);
        add(7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,        32'h0020006F, 0, 1, 0);
        add(7'h7F, 5'd9, 5'd9, 5'd9, 3'd7, 7'h7F, 32'hFFFFFFFF, 32'h00000000, 1, 1, 0);
        foreach (vecs[k]) begin
`ifdef INSTR_ENC_RANGE_CHECK_EN
            exp_err = vecs[k].err_on;
`else
            exp_err = vecs[k].err_off;
`endif
            set_fields(vecs[k].op, vecs[k].rd, vecs[k].rs1, vecs[k].rs2,
                       vecs[k].f3, vecs[k].f7, vecs[k].imm);
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_instr !== vecs[k].instr ||
                out_err !== exp_err || out_addr !== 10'(exp_addr)) begin
                errors++;
                $display("FAIL enc_%0d: v=%b instr=%h err=%b addr=%0d want 1/%h/%b/%0d",
                         k, out_valid, out_instr, out_err, out_addr,
                         vecs[k].instr, exp_err, exp_addr[9:0]);
            end
            if (vecs[k].rt) begin
                checks++;
                if (immgen(out_instr) !== vecs[k].imm) begin
                    errors++;
                    $display("FAIL roundtrip_%0d: imm=%h want %h",
                             k, immgen(out_instr), vecs[k].imm);
                end
            end
            exp_addr = exp_addr + 4;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b0;
        set_fields(7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h77777000);
        in_valid = 1'b1;
        @(posedge clk); #1;
        set_fields(7'h37, 5'd8, 5'd0, 5'd0, 3'd0, 7'd0, 32'h88888000);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_addr === 10'd0) begin
            errors++;
            $display("FAIL rst_pre: v=%b ready=%b addr=%0d want 1/0/nonzero",
                     out_valid, in_ready, out_addr);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_addr !== 10'd0 ||
            out_instr !== 32'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_async: v=%b addr=%0d instr=%h ready=%b want 0/0/0/1",
                     out_valid, out_addr, out_instr, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_stale_%0d: v=%b instr=%h want v=0",
                         i, out_valid, out_instr);
            end
        end
    endtask

    initial begin
        test_reset;
        test_backpressure;
        test_clear;
        test_back_to_back;
        test_encodings;
        test_reset_midstream;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Pipelined RISC-V RV32I instruction encoder: the inverse of the immediate generator. It takes instruction fields plus a sign-extended 32-bit immediate (the same value the immediate generator would produce as `ImmExt`) and packs them into a 32-bit instruction word. Each encoded word leaves with a byte address and an error flag, so a bench or program loader can stream words into the multicycle core's instruction memory. Any error-free output fed back through the immediate generator must return the original `in_imm`.

## Interface
- `WIDTH`, 32: instruction and immediate width. Only 32 is supported.
- `ADDR_W`, 10: width of the byte-address counter.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `clear` in 1: synchronous address-counter clear.
- `in_valid` in 1 / `in_ready` out 1: input handshake.
- `in_opcode` in 7: opcode. It selects the format.
- `in_rd`, `in_rs1`, `in_rs2` in 5 each: register fields.
- `in_funct3` in 3, `in_funct7` in 7: function fields.
- `in_imm` in 32: sign-extended immediate value, in `ImmExt` convention.
- `out_valid` out 1 / `out_ready` in 1: output handshake.
- `out_instr` out 32: encoded instruction.
- `out_addr` out ADDR_W: byte address assigned to `out_instr`.
- `out_err` out 1: the word is invalid or the immediate was not representable.

## Operation
- Opcodes decode to formats as follows:
  - 0110011 → R.
  - 0010011, 0000011, 1100111 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - Any other opcode → BAD.
- Packing per format:
  - R: {funct7, rs2, rs1, funct3, rd, op}; imm ignored.
  - I: {imm[11:0], rs1, funct3, rd, op}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
  - U: {imm[31:12], rd, op}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - Fields not used by a format are ignored.
- A BAD opcode gives `out_instr`=0 and `out_err`=1, always, independent of configuration.
- Range rules (active only when range checking is compiled in):
  - I and S: −2048..2047.
  - B: −4096..4094 and imm[0]=0.
  - J: −1048576..1048574 and imm[0]=0.
  - U: imm[11:0]=0.
  - A violation sets `out_err`=1. The word is still emitted, packed from the truncated immediate bits.
- Address counter:
  - Resets to 0.
  - Advances by 4 on every output handshake (`out_valid && out_ready`), including errored words.
  - Wraps modulo 2^ADDR_W.
  - `out_addr` shows the current counter value.
  - `clear` sets the counter to 0 next edge. If `clear` and a handshake occur in the same cycle, `clear` wins (next value 0).
  - `clear` does not flush the pipeline.

## Timing
- Two register stages. S1 holds the format plus packed word and error; S2 is the output register.
- A word accepted on edge k is on `out_*` with `out_valid`=1 after edge k+1. Latency is 2 edges, throughput is 1 word/cycle.
- Each stage loads when it is empty or its content is consumed in the same cycle.
- `in_ready` = !S1.valid || !S2.valid || `out_ready`. It is combinational from `out_ready`. Inputs never depend combinationally on `in_ready`.
- While `out_valid`=1 and `out_ready`=0, `out_instr`, `out_addr` and `out_err` stay stable. Up to two words are buffered, then `in_ready`=0.
- Reset values: `out_valid`=0, `out_instr`=0, `out_err`=0, `out_addr`=0, both stage valids 0. `in_ready` is 1 after reset.
- Reset asserted mid-stream drops all buffered words immediately, asynchronously.

## Configuration
- `INSTR_ENC_RANGE_CHECK_EN`
  - Defined: the range and alignment rules above drive `out_err`.
  - Undefined: no range logic. The immediate is silently truncated to the format's bits, and `out_err` flags only BAD opcodes.

## Structure
- Shared package `riscv_pkg` holds:
  - Opcode localparams (OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_REG).
  - Enum `fmt_e` {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD}.
- One combinational sub-module, `imm_packer`: (fmt, imm) → 32-bit immediate bit-scatter mask plus range error. It is the mirror of the immediate generator.
- The top level holds the opcode→fmt decode, the two stages, the handshake and the address counter.

## Test plan
- I-type: op 0010011, rd=4, rs1=6, f3=0, imm=30 → `out_instr`=0x01E30213, err=0, `out_addr`=0 after 2 edges. Round-trip through the immediate generator returns 30.
- S/B/J/U encodings:
  - S: rs2=5, rs1=6, f3=2, imm=8 → 0x00532423.
  - B: rs2=7, rs1=6, f3=1, imm=−4 → 0xFE731EE3.
  - J: rd=1, imm=16 → 0x010000EF.
  - LUI: rd=4, imm=0x12345000 → 0x12345237.
- Errors, with the macro defined:
  - I imm=2048 → err=1.
  - B imm=5 → err=1.
  - U imm=0x12345001 → err=1.
  - op 1111111 → instr=0, err=1.
  - With the macro undefined, the first three give err=0 and op 1111111 still gives err=1.
- Backpressure: hold `out_ready`=0 and offer 3 words → 2 are accepted, then `in_ready`=0 and `out_*` stay stable. Release → the words emerge in order at addresses 0, 4, 8.
- Address counter:
  - `clear` together with a handshake → next `out_addr`=0.
  - With ADDR_W=4, the 4th handshake wraps the counter 12 → 0.
- Reset mid-stream with 2 words buffered → `out_valid`=0 and `out_addr`=0 immediately. No stale word appears after reset is released.
